// File: rtl/keypad_digit_entry_if.sv
// Keypad entry bus: raw key lines and controls in, BCD strobe and entry register out.
// key_valid and error are single-cycle strobes with no back-pressure: the consumer takes bcd on the cycle key_valid is high; digits, digit_count and full are levels.
interface keypad_digit_entry_if #(
    parameter int NUM_KEYS   = 10,
    parameter int NUM_DIGITS = 4
);
    logic [NUM_KEYS-1:0]               keyboard;
    logic                              enablen;
    logic                              clear;
    logic [3:0]                        bcd;
    logic                              key_valid;
    logic                              error;
    logic [4*NUM_DIGITS-1:0]           digits;
    logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count;
    logic                              full;

    modport master (
        output keyboard, enablen, clear,
        input  bcd, key_valid, error, digits, digit_count, full
    );

    modport slave (
        input  keyboard, enablen, clear,
        output bcd, key_valid, error, digits, digit_count, full
    );
endinterface

// File: rtl/keypad_digit_entry.sv
// Debounced one-hot keypad encoder: accepts each press once, strobes its BCD code
// and shifts accepted digits into an N-digit entry register.
module keypad_digit_entry #(
    parameter int NUM_KEYS        = 10,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int NUM_DIGITS      = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    keypad_digit_entry_if.slave    kp,
    output logic [1:0]             state_dbg
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DC_W  = $clog2(NUM_DIGITS + 1);
    localparam int DW    = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DC_W-1:0]  DC_MAX   = DC_W'(NUM_DIGITS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HOLD      = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_KEYS-1:0]  ks;
    logic [NUM_KEYS-1:0]  key_q, key_d;
    logic [3:0]           idx_q, idx_d, ks_idx;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_armed_q, err_armed_d;
    logic                 ks_any, ks_multi;
    logic                 accept, err_fire;

    logic [3:0]           bcd_q;
    logic                 key_valid_q, error_q, full_q;
    logic [DW-1:0]        digits_q, digits_d, idx_ext;
    logic [DC_W-1:0]      count_q, count_d;

    always_comb begin
        ks_any   = |ks;
        ks_multi = |(ks & (ks - NUM_KEYS'(1)));
        ks_idx   = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (ks[i]) ks_idx = 4'(i);
        end
    end

    // err_armed drops once an error has fired, so a held multi-key pattern
    // reports once; any other sample or state re-arms it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        idx_d       = idx_q;
        err_armed_d = 1'b1;
        accept      = 1'b0;
        err_fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ks_multi) begin
                    err_fire    = err_armed_q;
                    err_armed_d = 1'b0;
                end else if (ks_any && !kp.enablen) begin
                    key_d   = ks;
                    idx_d   = ks_idx;
                    cnt_d   = '0;
                    state_d = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (ks != key_q || kp.enablen) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    accept  = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!ks_any) begin
                    cnt_d   = '0;
                    state_d = DEB_REL;
                end
            end
            DEB_REL: begin
                if (ks_any) begin
                    state_d = HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear empties the register first, so a simultaneous accept lands alone.
    always_comb begin
        idx_ext      = '0;
        idx_ext[3:0] = idx_q;
        digits_d     = digits_q;
        count_d      = count_q;
        if (kp.clear) begin
            digits_d = '0;
            count_d  = '0;
            if (accept) begin
                digits_d = idx_ext;
                count_d  = DC_W'(1);
            end
        end else if (accept && count_q != DC_MAX) begin
            digits_d = (digits_q << 4) | idx_ext;
            count_d  = count_q + DC_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ks          <= '0;
            key_q       <= '0;
            idx_q       <= '0;
            err_armed_q <= 1'b1;
            bcd_q       <= '0;
            key_valid_q <= 1'b0;
            error_q     <= 1'b0;
            digits_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ks          <= kp.keyboard;
            key_q       <= key_d;
            idx_q       <= idx_d;
            err_armed_q <= err_armed_d;
            key_valid_q <= accept;
            error_q     <= err_fire;
            if (accept) bcd_q <= idx_q;
            digits_q    <= digits_d;
            count_q     <= count_d;
            full_q      <= (count_d == DC_MAX);
        end
    end

    assign kp.bcd         = bcd_q;
    assign kp.key_valid   = key_valid_q;
    assign kp.error       = error_q;
    assign kp.digits      = digits_q;
    assign kp.digit_count = count_q;
    assign kp.full        = full_q;
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_keypad_digit_entry.sv
// Bench for keypad_digit_entry: run-length reference model feeds expected strobes
// into queues; a negedge monitor pops and compares them and the entry register.
module tb_keypad_digit_entry;
  localparam int NK = 10;
  localparam int DB = 4;
  localparam int ND = 4;
  localparam int DW = 4 * ND;
  localparam int CW = $clog2(ND + 1);

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  keypad_digit_entry_if #(.NUM_KEYS(NK), .NUM_DIGITS(ND)) kp ();
  logic [1:0] state_dbg;

  keypad_digit_entry #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .NUM_DIGITS(ND)
  ) dut (
    .clock(clock),
    .reset(reset),
    .kp(kp),
    .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [NK-1:0] onehot(int k);
    logic [NK-1:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  // ---------------- reference model ----------------
  // A press is accepted after DB+1 consecutive enabled samples of the same
  // single key; after that nothing is accepted until DB+1 consecutive empty
  // samples have been seen. Digits are a list capped at ND entries.
  int            cyc = 0;
  logic [NK-1:0] m_ks = '0;
  bit            locked = 0;
  int            zero_run = 0;
  int            press_run = 0;
  logic [NK-1:0] press_key = '0;
  bit            prev_multi = 0;
  int            entry[$];
  logic [3:0]    m_bcd = '0;
  logic [23:0]   exp_q[$];
  logic [19:0]   err_q[$];

  function automatic logic [DW-1:0] model_digits();
    logic [DW-1:0] r;
    r = '0;
    foreach (entry[i]) r = (r << 4) | DW'(entry[i]);
    return r;
  endfunction

  always @(posedge clock) begin
    logic [NK-1:0] v;
    bit multi, one, accepted;
    int idx;
    cyc++;
    if (reset) begin
      m_ks = '0; locked = 0; zero_run = 0; press_run = 0;
      prev_multi = 0; entry.delete(); m_bcd = '0;
    end else begin
      v = m_ks;
      m_ks = kp.keyboard;
      multi = ($countones(v) >= 2);
      one = ($countones(v) == 1);
      accepted = 0;
      idx = 0;
      for (int i = 0; i < NK; i++) if (v[i]) idx = i;
      if (locked) begin
        if (v == '0) begin
          zero_run++;
          if (zero_run == DB + 1) locked = 0;
        end else begin
          zero_run = 0;
        end
      end else if (one && !kp.enablen && (press_run == 0 || v == press_key)) begin
        press_key = v;
        press_run++;
        if (press_run == DB + 1) begin
          accepted = 1; locked = 1; zero_run = 0; press_run = 0;
        end
      end else begin
        if (multi && press_run == 0 && !prev_multi) err_q.push_back(20'(cyc));
        press_run = 0;
      end
      prev_multi = multi;
      if (accepted) begin
        m_bcd = 4'(idx);
        exp_q.push_back({20'(cyc), 4'(idx)});
      end
      if (kp.clear) begin
        entry.delete();
        if (accepted) entry.push_back(idx);
      end else if (accepted && entry.size() < ND) begin
        entry.push_back(idx);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int         kv_count = 0;
  int         err_count = 0;
  int         kv_last_cyc = 0;
  logic [3:0] kv_last_bcd = '0;

  always @(negedge clock) begin
    logic [23:0] e;
    logic [19:0] ec;
    if (kp.key_valid) begin
      kv_count++;
      kv_last_cyc = cyc;
      kv_last_bcd = kp.bcd;
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL kv_unexpected: key_valid with bcd=%0d at cycle %0d, none required", kp.bcd, cyc);
      end else begin
        e = exp_q.pop_front();
        check("kv_cycle", 32'(cyc), 32'(e[23:4]));
        check("kv_bcd", 32'(kp.bcd), 32'(e[3:0]));
      end
    end
    while (exp_q.size() > 0 && int'(exp_q[0][23:4]) <= cyc) begin
      e = exp_q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL kv_missing: key_valid absent at cycle %0d, required bcd=%0d", e[23:4], e[3:0]);
    end
    if (kp.error) begin
      err_count++;
      if (err_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL err_unexpected: error at cycle %0d, none required", cyc);
      end else begin
        ec = err_q.pop_front();
        check("err_cycle", 32'(cyc), 32'(ec));
      end
    end
    while (err_q.size() > 0 && int'(err_q[0]) <= cyc) begin
      ec = err_q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL err_missing: error absent at cycle %0d", ec);
    end
    check("digits", 32'(kp.digits), 32'(model_digits()));
    check("digit_count", 32'(kp.digit_count), 32'(entry.size()));
    check("full", 32'(kp.full), 32'(entry.size() == ND));
    check("bcd_hold", 32'(kp.bcd), 32'(m_bcd));
  end

  // ---------------- driver tasks ----------------
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press(int key, int hold, int rel);
    kp.keyboard = onehot(key);
    tick(hold);
    kp.keyboard = '0;
    tick(rel);
  endtask

  task automatic rand_cycles(int n);
    repeat (n) begin
      kp.enablen = ($urandom_range(0, 9) == 0);
      kp.clear = ($urandom_range(0, 29) == 0);
      tick(1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0, kv0, er0;
    logic [NK-1:0] pat;
    int a, b, r;

    // 1. reset with random keyboard
    reset = 1'b1;
    kp.enablen = 1'b0;
    kp.clear = 1'b0;
    kp.keyboard = NK'($urandom);
    tick(1);
    kp.keyboard = NK'($urandom);
    tick(1);
    reset = 1'b0;
    kp.keyboard = '0;
    @(negedge clock);
    check("rst_bcd", 32'(kp.bcd), 0);
    check("rst_key_valid", 32'(kp.key_valid), 0);
    check("rst_error", 32'(kp.error), 0);
    check("rst_digits", 32'(kp.digits), 0);
    check("rst_count", 32'(kp.digit_count), 0);
    check("rst_full", 32'(kp.full), 0);
    check("rst_state_idle", 32'(state_dbg), 0);
    tick(2);

    // 2. key 7 held 10 cycles, released 6
    kv0 = kv_count;
    c0 = cyc;
    kp.keyboard = NK'(10'b0010000000);
    tick(10);
    kp.keyboard = '0;
    tick(6);
    check("t2_kv_pulses", 32'(kv_count - kv0), 1);
    check("t2_latency", 32'(kv_last_cyc), 32'(c0 + DB + 2));
    check("t2_bcd", 32'(kv_last_bcd), 7);
    check("t2_digits", 32'(kp.digits), 32'h0007);
    check("t2_count", 32'(kp.digit_count), 1);

    // 3. bouncy key 3
    kv0 = kv_count;
    kp.keyboard = onehot(3);
    tick(2);
    kp.keyboard = '0;
    tick(1);
    c0 = cyc;
    press(3, 8, 8);
    check("t3_kv_pulses", 32'(kv_count - kv0), 1);
    check("t3_latency", 32'(kv_last_cyc), 32'(c0 + DB + 2));
    check("t3_bcd", 32'(kv_last_bcd), 3);

    // 4. two keys at once, then a glitch during hold
    kv0 = kv_count;
    er0 = err_count;
    kp.keyboard = NK'(10'b0000100001);
    tick(6);
    kp.keyboard = '0;
    tick(6);
    check("t4_err_pulses", 32'(err_count - er0), 1);
    check("t4_no_kv", 32'(kv_count - kv0), 0);
    check("t4_digits", 32'(kp.digits), 32'h0073);
    kp.keyboard = onehot(2);
    tick(10);
    kp.keyboard = '0;
    tick(1);
    press(2, 6, 8);
    check("t4_glitch_single", 32'(kv_count - kv0), 1);

    // 5. fill, overflow, clear with accept
    kp.clear = 1'b1;
    tick(1);
    kp.clear = 1'b0;
    for (int k = 1; k <= 4; k++) press(k, 7, 8);
    check("t5_digits_1234", 32'(kp.digits), 32'h1234);
    check("t5_full", 32'(kp.full), 1);
    kv0 = kv_count;
    press(5, 7, 8);
    check("t5_overflow_kv", 32'(kv_count - kv0), 1);
    check("t5_overflow_bcd", 32'(kv_last_bcd), 5);
    check("t5_overflow_digits", 32'(kp.digits), 32'h1234);
    kp.keyboard = onehot(9);
    tick(DB + 1);
    kp.clear = 1'b1;
    tick(1);
    kp.clear = 1'b0;
    tick(3);
    kp.keyboard = '0;
    tick(8);
    check("t5_clear_digits", 32'(kp.digits), 32'h0009);
    check("t5_clear_count", 32'(kp.digit_count), 1);
    check("t5_clear_full", 32'(kp.full), 0);

    // 6. enablen blocking, abort, and reset mid-debounce
    kv0 = kv_count;
    kp.enablen = 1'b1;
    press(6, 10, 8);
    kp.enablen = 1'b0;
    kp.keyboard = onehot(4);
    tick(2);
    kp.enablen = 1'b1;
    tick(8);
    kp.keyboard = '0;
    tick(2);
    kp.enablen = 1'b0;
    tick(6);
    check("t6_no_kv", 32'(kv_count - kv0), 0);
    kp.keyboard = onehot(8);
    tick(3);
    reset = 1'b1;
    tick(1);
    kp.keyboard = '0;
    reset = 1'b0;
    @(negedge clock);
    check("t6_rst_digits", 32'(kp.digits), 0);
    check("t6_rst_count", 32'(kp.digit_count), 0);
    check("t6_rst_bcd", 32'(kp.bcd), 0);
    check("t6_rst_state", 32'(state_dbg), 0);
    tick(8);
    check("t6_reset_abort", 32'(kv_count - kv0), 0);

    // random segments separated by idle gaps
    for (int s = 0; s < 300; s++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        pat = onehot($urandom_range(0, NK - 1));
      end else if (r < 85) begin
        a = $urandom_range(0, NK - 1);
        b = (a + 1 + $urandom_range(0, NK - 2)) % NK;
        pat = onehot(a) | onehot(b);
      end else begin
        pat = '0;
      end
      kp.keyboard = pat;
      rand_cycles($urandom_range(1, 10));
      kp.keyboard = '0;
      rand_cycles($urandom_range(1, 8));
    end
    kp.enablen = 1'b0;
    kp.clear = 1'b0;
    kp.keyboard = '0;
    tick(12);
    check("drain_kv_queue", 32'(exp_q.size()), 0);
    check("drain_err_queue", 32'(err_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
